ccff_chain_loader: RTL

//  Sequencer that loads the configuration flip-flop (CCFF) scan chain of the

---
 rtl/ccff_chain_loader_if.sv | 21 ++
 rtl/ccff_chain_loader.sv | 128 ++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream into the CCFF chain loader: valid/ready handshake.
// master drives words (programming interface), slave is the loader.
interface ccff_chain_loader_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic [DATA_W-1:0] bs_data;
  logic              bs_valid;
  logic              bs_ready;

  modport master (
    output bs_data,
    output bs_valid,
    input  bs_ready
  );

  modport slave (
    input  bs_data,
    input  bs_valid,
    output bs_ready
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Loads the fabric CCFF scan chain from a word stream, LSB-first, one bit per
// prog_clk, then raises config_done and releases the fabric reset.
module ccff_chain_loader #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CHAIN_LEN = 1024,
  localparam int unsigned CNT_W    = $clog2(CHAIN_LEN + 1)
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  input  logic                start,
  input  logic                abort,
  ccff_chain_loader_if.slave  bs,
  output logic                ccff_head,
  output logic                ccff_en,
  output logic                busy,
  output logic                config_done,
  output logic                fabric_reset_n,
  output logic [CNT_W-1:0]    bits_left
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    bits_left_q, bits_left_d;
  logic                head_q, head_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                frst_n_q, frst_n_d;
  logic                in_load_shift;

  assign in_load_shift = (state_q == StLoad) || (state_q == StShift);

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    bits_left_d = bits_left_q;
    head_d      = 1'b0;
    en_d        = 1'b0;
    done_d      = done_q;
    frst_n_d    = frst_n_q;

    // abort outranks everything, including a same-cycle handshake
    if (abort && in_load_shift) begin
      state_d     = StIdle;
      bits_left_d = '0;
      done_d      = 1'b0;
      frst_n_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d     = StLoad;
            bits_left_d = CNT_W'(CHAIN_LEN);
            done_d      = 1'b0;
            frst_n_d    = 1'b0;
          end
        end
        StLoad: begin
          if (bs.bs_valid) begin
            state_d = StShift;
            word_d  = bs.bs_data >> 1;
            head_d  = bs.bs_data[0];
            en_d    = 1'b1;
            idx_d   = '0;
          end
        end
        StShift: begin
          // head_q/en_q already present bit idx_q during this cycle
          bits_left_d = bits_left_q - CNT_W'(1);
          idx_d       = idx_q + IDX_W'(1);
          if (bits_left_q == CNT_W'(1)) begin
            state_d  = StDone;
            done_d   = 1'b1;
            frst_n_d = 1'b1;
          end else if (idx_q == IDX_W'(DATA_W - 1)) begin
            state_d = StLoad;
          end else begin
            head_d = word_q[0];
            word_d = word_q >> 1;
            en_d   = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d == StLoad) || (state_d == StShift);
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q     <= StIdle;
      word_q      <= '0;
      idx_q       <= '0;
      bits_left_q <= '0;
      head_q      <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frst_n_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      bits_left_q <= bits_left_d;
      head_q      <= head_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frst_n_q    <= frst_n_d;
    end
  end

  assign bs.bs_ready     = (state_q == StLoad);
  assign ccff_head       = head_q;
  assign ccff_en         = en_q;
  assign busy            = busy_q;
  assign config_done     = done_q;
  assign fabric_reset_n  = frst_n_q;
  assign bits_left       = bits_left_q;

endmodule
